// File: rtl/thor2022_mpu_bus_pkg.sv
// Shared types and constants for the MPU internal bus arbiter.
//   state_e : arbiter tenure states (IDLE, ACCESS, RESP, HOLD)
//   sel_e   : slave select produced by the address decoder
//   PIT_BASE_DEF / PIC_BASE_DEF : default adr[31:12] matches for PIT / PIC
//   TO_W    : width of the access timeout counter
package thor2022_mpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_PIT = 2'd0,
    SEL_PIC = 2'd1,
    SEL_EXT = 2'd2
  } sel_e;

  localparam logic [19:0] PIT_BASE_DEF = 20'hFF960;
  localparam logic [19:0] PIC_BASE_DEF = 20'hFF9C0;
  localparam int unsigned TO_W         = 8;

endpackage

// File: rtl/thor2022_mpu_bus_decode.sv
// Combinational address decoder: adr[31:12] -> slave select.
//   adr_hi  : in  20  upper address bits adr[31:12]
//   slv_sel : out 2   sel_e encoding (PIT, else PIC, else external bus)
// Also instantiated stand-alone by the MPU top for debug visibility.
module thor2022_mpu_bus_decode
  import thor2022_mpu_bus_pkg::*;
#(
  parameter logic [19:0] PIT_BASE = PIT_BASE_DEF,
  parameter logic [19:0] PIC_BASE = PIC_BASE_DEF
) (
  input  logic [19:0] adr_hi,
  output logic [1:0]  slv_sel
);

  always_comb begin
    slv_sel = SEL_EXT;
    if (adr_hi == PIT_BASE) begin
      slv_sel = SEL_PIT;
    end else if (adr_hi == PIC_BASE) begin
      slv_sel = SEL_PIC;
    end
  end

endmodule

// File: rtl/thor2022_mpu_bus_arb.sv
// Two-master round-robin arbiter and slave router for the MPU's 128-bit
// Wishbone-classic bus. m0 = CPU, m1 = DMA/debug.
//   clk_i, rst_i (async, active-low)
//   m{0,1}_cyc/stb/we/sel/adr/dat_i : master requests (cyc held = lock)
//   m{0,1}_ack/err_o, m{0,1}_dat_o  : registered one-cycle responses
//   s_cyc/stb/we/sel/adr/dat_o      : registered slave-side bus
//   pit/pic/ext_cs_o                : one-hot select, valid with s_stb_o
//   pit/pic/ext_ack_i, ext_err_i, pit/pic/ext_dat_i : slave responses
// Optional (macro MPU_BUS_ERRLOG_EN): err_clr_i, err_adr_o, err_mst_o,
// err_vld_o -- sticky capture of the first bus error.
module thor2022_mpu_bus_arb
  import thor2022_mpu_bus_pkg::*;
#(
  parameter logic [19:0] PIT_BASE = PIT_BASE_DEF,
  parameter logic [19:0] PIC_BASE = PIC_BASE_DEF,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         m0_cyc_i,
  input  logic         m1_cyc_i,
  input  logic         m0_stb_i,
  input  logic         m1_stb_i,
  input  logic         m0_we_i,
  input  logic         m1_we_i,
  input  logic [15:0]  m0_sel_i,
  input  logic [15:0]  m1_sel_i,
  input  logic [31:0]  m0_adr_i,
  input  logic [31:0]  m1_adr_i,
  input  logic [127:0] m0_dat_i,
  input  logic [127:0] m1_dat_i,
  output logic         m0_ack_o,
  output logic         m1_ack_o,
  output logic         m0_err_o,
  output logic         m1_err_o,
  output logic [127:0] m0_dat_o,
  output logic [127:0] m1_dat_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [15:0]  s_sel_o,
  output logic [31:0]  s_adr_o,
  output logic [127:0] s_dat_o,
  output logic         pit_cs_o,
  output logic         pic_cs_o,
  output logic         ext_cs_o,
  input  logic         pit_ack_i,
  input  logic         pic_ack_i,
  input  logic         ext_ack_i,
  input  logic         ext_err_i,
  input  logic [31:0]  pit_dat_i,
  input  logic [31:0]  pic_dat_i,
`ifdef MPU_BUS_ERRLOG_EN
  input  logic         err_clr_i,
  output logic [31:0]  err_adr_o,
  output logic         err_mst_o,
  output logic         err_vld_o,
`endif
  input  logic [127:0] ext_dat_i
);

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic            gnt_q, gnt_d;
  logic            rr_q, rr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            s_cyc_q, s_cyc_d;
  logic            s_stb_q, s_stb_d;
  logic            s_we_q, s_we_d;
  logic [15:0]     s_sel_q, s_sel_d;
  logic [31:0]     s_adr_q, s_adr_d;
  logic [127:0]    s_dat_q, s_dat_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [127:0]    dat0_q, dat0_d, dat1_q, dat1_d;

  logic            req0, req1, pick;
  logic            lat_mst, lat_we;
  logic [15:0]     lat_sel;
  logic [31:0]     lat_adr;
  logic [127:0]    lat_dat;
  logic [1:0]      dec_sel;
  sel_e            dec_sel_e;
  logic            g_cyc, g_stb;
  logic            slv_ack, ext_err_hit, to_hit;
  logic [127:0]    rd_dat, resp_dat;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  // Contention goes to rr_q; otherwise the only requester (req1 decides).
  assign pick = (req0 & req1) ? rr_q : req1;

  // In HOLD the locked master is relatched without re-arbitration.
  assign lat_mst = (state_q == HOLD) ? gnt_q : pick;
  assign lat_we  = lat_mst ? m1_we_i  : m0_we_i;
  assign lat_sel = lat_mst ? m1_sel_i : m0_sel_i;
  assign lat_adr = lat_mst ? m1_adr_i : m0_adr_i;
  assign lat_dat = lat_mst ? m1_dat_i : m0_dat_i;

  assign g_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;
  assign g_stb = gnt_q ? m1_stb_i : m0_stb_i;

  thor2022_mpu_bus_decode #(
    .PIT_BASE (PIT_BASE),
    .PIC_BASE (PIC_BASE)
  ) u_decode (
    .adr_hi  (lat_adr[31:12]),
    .slv_sel (dec_sel)
  );

  assign dec_sel_e = sel_e'(dec_sel);

  always_comb begin
    slv_ack = 1'b0;
    rd_dat  = ext_dat_i;
    case (sel_q)
      SEL_PIT: begin
        slv_ack = pit_ack_i;
        rd_dat  = {4{pit_dat_i}};
      end
      SEL_PIC: begin
        slv_ack = pic_ack_i;
        rd_dat  = {4{pic_dat_i}};
      end
      default: begin
        slv_ack = ext_ack_i;
        rd_dat  = ext_dat_i;
      end
    endcase
  end

  assign ext_err_hit = (sel_q == SEL_EXT) & ext_err_i;
  assign to_hit      = (cnt_q == TO_W'(TIMEOUT));
  assign resp_dat    = s_we_q ? '0 : rd_dat;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    s_cyc_d = s_cyc_q;
    s_stb_d = s_stb_q;
    s_we_d  = s_we_q;
    s_sel_d = s_sel_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    dat0_d  = '0;
    dat1_d  = '0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          gnt_d   = pick;
          sel_d   = dec_sel_e;
          cnt_d   = '0;
          s_cyc_d = 1'b1;
          s_stb_d = 1'b1;
          s_we_d  = lat_we;
          s_sel_d = lat_sel;
          s_adr_d = lat_adr;
          s_dat_d = lat_dat;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + TO_W'(1);
        if (slv_ack) begin
          state_d = RESP;
          s_stb_d = 1'b0;
          if (gnt_q) begin
            ack1_d = 1'b1;
            dat1_d = resp_dat;
          end else begin
            ack0_d = 1'b1;
            dat0_d = resp_dat;
          end
        end else if (ext_err_hit | to_hit) begin
          state_d = RESP;
          s_stb_d = 1'b0;
          err1_d  = gnt_q;
          err0_d  = ~gnt_q;
        end
      end

      RESP: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (!g_cyc) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
          rr_d    = ~gnt_q;
        end else if (g_stb) begin
          state_d = ACCESS;
          sel_d   = dec_sel_e;
          cnt_d   = '0;
          s_stb_d = 1'b1;
          s_we_d  = lat_we;
          s_sel_d = lat_sel;
          s_adr_d = lat_adr;
          s_dat_d = lat_dat;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_PIT;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      dat0_q  <= '0;
      dat1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_sel_q <= s_sel_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
    end
  end

`ifdef MPU_BUS_ERRLOG_EN
  logic        err_evt;
  logic [31:0] log_adr_q;
  logic        log_mst_q, log_vld_q;

  assign err_evt = (state_q == ACCESS) & ~slv_ack & (ext_err_hit | to_hit);

  // A clear coinciding with a new error still captures that error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      log_adr_q <= '0;
      log_mst_q <= 1'b0;
      log_vld_q <= 1'b0;
    end else if (err_evt && (!log_vld_q || err_clr_i)) begin
      log_adr_q <= s_adr_q;
      log_mst_q <= gnt_q;
      log_vld_q <= 1'b1;
    end else if (err_clr_i) begin
      log_vld_q <= 1'b0;
    end
  end

  assign err_adr_o = log_adr_q;
  assign err_mst_o = log_mst_q;
  assign err_vld_o = log_vld_q;
`endif

  assign m0_ack_o = ack0_q;
  assign m1_ack_o = ack1_q;
  assign m0_err_o = err0_q;
  assign m1_err_o = err1_q;
  assign m0_dat_o = dat0_q;
  assign m1_dat_o = dat1_q;
  assign s_cyc_o  = s_cyc_q;
  assign s_stb_o  = s_stb_q;
  assign s_we_o   = s_we_q;
  assign s_sel_o  = s_sel_q;
  assign s_adr_o  = s_adr_q;
  assign s_dat_o  = s_dat_q;
  assign pit_cs_o = s_stb_q & (sel_q == SEL_PIT);
  assign pic_cs_o = s_stb_q & (sel_q == SEL_PIC);
  assign ext_cs_o = s_stb_q & (sel_q == SEL_EXT);

endmodule

// File: tb/tb_thor2022_mpu_bus_arb.sv
// Directed self-checking bench for thor2022_mpu_bus_arb.
module tb_thor2022_mpu_bus_arb;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
  logic [15:0]  m0_sel_i, m1_sel_i;
  logic [31:0]  m0_adr_i, m1_adr_i;
  logic [127:0] m0_dat_i, m1_dat_i;
  logic         m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [127:0] m0_dat_o, m1_dat_o;
  logic         s_cyc_o, s_stb_o, s_we_o;
  logic [15:0]  s_sel_o;
  logic [31:0]  s_adr_o;
  logic [127:0] s_dat_o;
  logic         pit_cs_o, pic_cs_o, ext_cs_o;
  logic         pit_ack_i, pic_ack_i, ext_ack_i, ext_err_i;
  logic [31:0]  pit_dat_i, pic_dat_i;
  logic [127:0] ext_dat_i;
`ifdef MPU_BUS_ERRLOG_EN
  logic         err_clr_i;
  logic [31:0]  err_adr_o;
  logic         err_mst_o, err_vld_o;
`endif

  int checks = 0;
  int errors = 0;

  thor2022_mpu_bus_arb #(
    .PIT_BASE (20'hFF960),
    .PIC_BASE (20'hFF9C0),
    .TIMEOUT  (255)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .m0_cyc_i (m0_cyc_i), .m1_cyc_i (m1_cyc_i),
    .m0_stb_i (m0_stb_i), .m1_stb_i (m1_stb_i),
    .m0_we_i (m0_we_i), .m1_we_i (m1_we_i),
    .m0_sel_i (m0_sel_i), .m1_sel_i (m1_sel_i),
    .m0_adr_i (m0_adr_i), .m1_adr_i (m1_adr_i),
    .m0_dat_i (m0_dat_i), .m1_dat_i (m1_dat_i),
    .m0_ack_o (m0_ack_o), .m1_ack_o (m1_ack_o),
    .m0_err_o (m0_err_o), .m1_err_o (m1_err_o),
    .m0_dat_o (m0_dat_o), .m1_dat_o (m1_dat_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
    .s_sel_o (s_sel_o), .s_adr_o (s_adr_o), .s_dat_o (s_dat_o),
    .pit_cs_o (pit_cs_o), .pic_cs_o (pic_cs_o), .ext_cs_o (ext_cs_o),
    .pit_ack_i (pit_ack_i), .pic_ack_i (pic_ack_i), .ext_ack_i (ext_ack_i),
    .ext_err_i (ext_err_i),
    .pit_dat_i (pit_dat_i), .pic_dat_i (pic_dat_i),
`ifdef MPU_BUS_ERRLOG_EN
    .err_clr_i (err_clr_i), .err_adr_o (err_adr_o),
    .err_mst_o (err_mst_o), .err_vld_o (err_vld_o),
`endif
    .ext_dat_i (ext_dat_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
    pit_ack_i = 0; pic_ack_i = 0; ext_ack_i = 0; ext_err_i = 0;
    pit_dat_i = '0; pic_dat_i = '0; ext_dat_i = '0;
`ifdef MPU_BUS_ERRLOG_EN
    err_clr_i = 0;
`endif
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 0;
    tick(); tick();
    rst_i = 1;
  endtask

  // Ticks until any master ack/err appears or the budget runs out.
  task automatic wait_resp(input int budget, output int n, output bit m0_hit);
    n = 0;
    m0_hit = 0;
    do begin
      tick();
      n++;
      m0_hit |= (m0_ack_o | m0_err_o);
    end while (!(m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) && n < budget);
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    apply_reset();
    ctl = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o,
           pit_cs_o, pic_cs_o, ext_cs_o};
    checks++;
    if (ctl !== 10'b0) begin errors++; $display("FAIL reset_ctl: got %b exp 0", ctl); end
    checks++;
    if ({s_adr_o, s_sel_o} !== 48'h0) begin errors++; $display("FAIL reset_adr: got %h exp 0", {s_adr_o, s_sel_o}); end
    checks++;
    if ({m0_dat_o, m1_dat_o, s_dat_o} !== 384'h0) begin errors++; $display("FAIL reset_dat: got nonzero exp 0"); end
  endtask

  task automatic test_pit_read();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 16'hFFFF;
    m0_adr_i = 32'hFF960010; m0_dat_i = {4{32'hDEADBEEF}};
    tick();
    checks++;
    if ({s_cyc_o, s_stb_o, pit_cs_o, pic_cs_o, ext_cs_o} !== 5'b11100) begin
      errors++; $display("FAIL pit_grant: got %b exp 11100", {s_cyc_o, s_stb_o, pit_cs_o, pic_cs_o, ext_cs_o});
    end
    checks++;
    if (s_adr_o !== 32'hFF960010) begin errors++; $display("FAIL pit_adr: got %h exp ff960010", s_adr_o); end
    tick();
    checks++;
    if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL pit_early_ack: got %b exp 0", m0_ack_o); end
    pit_dat_i = 32'h12345678; pit_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m1_ack_o, s_stb_o} !== 3'b100) begin
      errors++; $display("FAIL pit_ack: got %b exp 100", {m0_ack_o, m1_ack_o, s_stb_o});
    end
    checks++;
    if (m0_dat_o !== 128'h12345678_12345678_12345678_12345678) begin
      errors++; $display("FAIL pit_dat: got %h exp 12345678 x4", m0_dat_o);
    end
    pit_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    checks++;
    if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL pit_ack_pulse: got %b exp 0", m0_ack_o); end
    tick();
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL pit_release: got %b exp 0", s_cyc_o); end
  endtask

  task automatic test_arbitration();
    apply_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 16'hFFFF; m0_adr_i = 32'hFF960000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 16'hFFFF; m1_adr_i = 32'hFF9C0000;
    tick();
    checks++;
    if (s_adr_o !== 32'hFF960000) begin errors++; $display("FAIL arb_first_m0: got %h exp ff960000", s_adr_o); end
    pit_dat_i = 32'hA5A5A5A5; pit_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL arb_m0_ack: got %b exp 10", {m0_ack_o, m1_ack_o}); end
    pit_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL arb_m0_release: got %b exp 0", s_cyc_o); end
    tick();
    checks++;
    if ({s_adr_o, pic_cs_o} !== {32'hFF9C0000, 1'b1}) begin
      errors++; $display("FAIL arb_m1_grant: got %h/%b exp ff9c0000/1", s_adr_o, pic_cs_o);
    end
    pic_dat_i = 32'h0BADF00D; pic_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b01 || m1_dat_o !== {4{32'h0BADF00D}}) begin
      errors++; $display("FAIL arb_m1_ack: got %b/%h exp 01/0badf00d x4", {m0_ack_o, m1_ack_o}, m1_dat_o);
    end
    pic_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_rr_alternate();
    // Pointer is back at m0 here; a solo m0 tenure hands priority to m1.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hFF960020;
    tick();
    pit_ack_i = 1;
    tick();
    checks++;
    if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL rr_solo_ack: got %b exp 1", m0_ack_o); end
    pit_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hFF960030;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hFF960040;
    tick();
    checks++;
    if (s_adr_o !== 32'hFF960040) begin errors++; $display("FAIL rr_m1_wins: got %h exp ff960040", s_adr_o); end
    pit_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b01) begin errors++; $display("FAIL rr_m1_ack: got %b exp 01", {m0_ack_o, m1_ack_o}); end
    pit_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick(); tick();
    checks++;
    if (s_adr_o !== 32'hFF960030) begin errors++; $display("FAIL rr_m0_later: got %h exp ff960030", s_adr_o); end
    pit_ack_i = 1;
    tick();
    checks++;
    if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL rr_m0_ack: got %b exp 1", m0_ack_o); end
    pit_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_ext();
    int n;
    bit m0_hit;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h00005000;
    tick();
    checks++;
    if ({pit_cs_o, pic_cs_o, ext_cs_o} !== 3'b001) begin
      errors++; $display("FAIL ext_cs: got %b exp 001", {pit_cs_o, pic_cs_o, ext_cs_o});
    end
    pit_ack_i = 1; pic_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m0_err_o, s_stb_o} !== 3'b001) begin
      errors++; $display("FAIL ext_foreign_ack: got %b exp 001", {m0_ack_o, m0_err_o, s_stb_o});
    end
    pit_ack_i = 0; pic_ack_i = 0;
    ext_dat_i = 128'h0123456789ABCDEF_FEDCBA9876543210; ext_ack_i = 1;
    tick();
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
      errors++; $display("FAIL ext_read: got %b/%h exp 1/0123456789abcdeffedcba9876543210", m0_ack_o, m0_dat_o);
    end
    ext_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00005010;
    tick();
    ext_err_i = 1;
    wait_resp(5, n, m0_hit);
    checks++;
    if ({m0_err_o, m0_ack_o, n} !== {2'b10, 32'd1} || m0_dat_o !== 128'h0) begin
      errors++; $display("FAIL ext_err: got err=%b ack=%b n=%0d dat=%h exp 1/0/1/0", m0_err_o, m0_ack_o, n, m0_dat_o);
    end
    ext_err_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    bit m0_hit;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 16'h00F0;
    m1_adr_i = 32'h00001000; m1_dat_i = {4{32'h11111111}};
    tick();
    checks++;
    if ({ext_cs_o, s_we_o, s_sel_o, s_dat_o} !== {1'b1, 1'b1, 16'h00F0, {4{32'h11111111}}}) begin
      errors++; $display("FAIL to_latch: got cs=%b we=%b sel=%h exp 1/1/00f0", ext_cs_o, s_we_o, s_sel_o);
    end
    wait_resp(300, n, m0_hit);
    checks++;
    if (n !== 256) begin errors++; $display("FAIL to_latency: got %0d exp 256", n); end
    checks++;
    if ({m1_err_o, m1_ack_o, s_stb_o, m0_hit} !== 4'b1000) begin
      errors++; $display("FAIL to_err: got %b exp 1000", {m1_err_o, m1_ack_o, s_stb_o, m0_hit});
    end
    checks++;
    if (m1_dat_o !== 128'h0) begin errors++; $display("FAIL to_dat: got %h exp 0", m1_dat_o); end
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    tick();
    checks++;
    if (m1_err_o !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b exp 0", m1_err_o); end
    tick();
  endtask

  task automatic test_locked();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'hFF9C0000;
    tick();
    checks++;
    if ({s_adr_o, pic_cs_o} !== {32'hFF9C0000, 1'b1}) begin
      errors++; $display("FAIL lock_beat1: got %h/%b exp ff9c0000/1", s_adr_o, pic_cs_o);
    end
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hFF960000;
    pic_dat_i = 32'h11112222; pic_ack_i = 1;
    tick();
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== {4{32'h11112222}}) begin
      errors++; $display("FAIL lock_ack1: got %b/%h exp 1/11112222 x4", m0_ack_o, m0_dat_o);
    end
    pic_ack_i = 0; m0_adr_i = 32'hFF9C0004;
    tick(); tick();
    checks++;
    if ({s_adr_o, pic_cs_o, s_stb_o} !== {32'hFF9C0004, 2'b11}) begin
      errors++; $display("FAIL lock_beat2: got %h/%b/%b exp ff9c0004/1/1", s_adr_o, pic_cs_o, s_stb_o);
    end
    pic_dat_i = 32'h33334444; pic_ack_i = 1;
    tick();
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_dat_o !== {4{32'h33334444}}) begin
      errors++; $display("FAIL lock_ack2: got %b/%h exp 10/33334444 x4", {m0_ack_o, m1_ack_o}, m0_dat_o);
    end
    pic_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick(); tick();
    checks++;
    if ({s_adr_o, pit_cs_o} !== {32'hFF960000, 1'b1}) begin
      errors++; $display("FAIL lock_m1_after: got %h/%b exp ff960000/1", s_adr_o, pit_cs_o);
    end
    pit_ack_i = 1;
    tick();
    checks++;
    if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL lock_m1_ack: got %b exp 1", m1_ack_o); end
    pit_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit stray;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00003000;
    tick(); tick();
    checks++;
    if ({s_stb_o, ext_cs_o} !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b exp 11", {s_stb_o, ext_cs_o}); end
    #2 rst_i = 0;
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, ext_cs_o, m0_ack_o, m0_err_o, s_adr_o} !== 37'h0) begin
      errors++; $display("FAIL rst_async: got cyc=%b stb=%b cs=%b adr=%h exp 0", s_cyc_o, s_stb_o, ext_cs_o, s_adr_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0; ext_ack_i = 1;
    #3 rst_i = 1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      stray |= (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o | s_cyc_o);
    end
    ext_ack_i = 0;
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %b exp 0", stray); end
  endtask

`ifdef MPU_BUS_ERRLOG_EN
  task automatic test_errlog();
    int n;
    bit m0_hit;
    apply_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h00002000;
    tick();
    wait_resp(300, n, m0_hit);
    checks++;
    if ({m1_err_o, err_vld_o, err_mst_o, err_adr_o} !== {3'b111, 32'h00002000}) begin
      errors++; $display("FAIL log_first: got %b/%b/%b/%h exp 1/1/1/00002000", m1_err_o, err_vld_o, err_mst_o, err_adr_o);
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00004000;
    tick();
    wait_resp(300, n, m0_hit);
    checks++;
    if ({m0_err_o, err_vld_o, err_mst_o, err_adr_o} !== {3'b111, 32'h00002000}) begin
      errors++; $display("FAIL log_retain: got %b/%b/%b/%h exp 1/1/1/00002000", m0_err_o, err_vld_o, err_mst_o, err_adr_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    checks++;
    if (err_vld_o !== 1'b0) begin errors++; $display("FAIL log_clear: got %b exp 0", err_vld_o); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_i = 0;
    test_reset();
    test_pit_read();
    test_arbitration();
    test_rr_alternate();
    test_ext();
    test_timeout();
    test_locked();
    test_reset_mid();
`ifdef MPU_BUS_ERRLOG_EN
    test_errlog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thor2022_mpu_bus_arb.md
Name: thor2022_mpu_bus_arb

Overview:
Two-master arbiter and slave router for the MPU's internal 128-bit Wishbone-classic bus. Master 0 is the CPU; master 1 is a DMA/debug requester. Grants one master per bus tenure by round-robin and decodes its address to the PIT, the PIC or the external bus. Returns one registered ack, err and read data, and generates a bus error on timeout.

Parameters:
PIT_BASE, 20'hFF960, adr[31:12] match selecting the PIT
PIC_BASE, 20'hFF9C0, adr[31:12] match selecting the PIC
TIMEOUT, 255, cycles in ACCESS before a bus error is forced (8-bit counter)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
m0_cyc_i, m1_cyc_i  in  1  master cycle valid; held high keeps the tenure (lock)
m0_stb_i, m1_stb_i  in  1  master strobe
m0_we_i, m1_we_i  in  1  write enable
m0_sel_i, m1_sel_i  in  16  byte lane selects
m0_adr_i, m1_adr_i  in  32  byte address
m0_dat_i, m1_dat_i  in  128  write data
m0_ack_o, m1_ack_o  out  1  one-cycle ack pulse
m0_err_o, m1_err_o  out  1  one-cycle error pulse
m0_dat_o, m1_dat_o  out  128  read data, valid with ack
s_cyc_o, s_stb_o, s_we_o  out  1  registered slave-side controls
s_sel_o  out  16  registered selects
s_adr_o  out  32  registered address
s_dat_o  out  128  registered write data
pit_cs_o, pic_cs_o, ext_cs_o  out  1  one-hot slave select, valid while s_stb_o is high
pit_ack_i, pic_ack_i, ext_ack_i  in  1  slave acks
ext_err_i  in  1  external bus error
pit_dat_i, pic_dat_i  in  32  32-bit peripheral read data
ext_dat_i  in  128  external read data

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0 (favours m0), timeout counter 0.
- IDLE: if any mX_cyc_i&mX_stb_i, grant. If both request, grant the master equal to rr_ptr; otherwise grant the sole requester. Latch that master's we/sel/adr/dat into the s_* registers and set the one-hot cs from the adr[31:12] decode (PIT, else PIC, else ext). Go to ACCESS. s_cyc_o/s_stb_o are high the cycle after the request is first seen.
- ACCESS: hold s_* stable and increment the counter.
  - Selected slave ack → RESP with ack.
  - ext_err_i, when ext is selected → RESP with err.
  - Counter==TIMEOUT → RESP with err.
  - Acks from non-selected slaves are ignored.
- RESP:
  - Drop s_stb_o.
  - Pulse the granted master's ack_o or err_o for exactly one cycle.
  - Read data is registered in the same cycle: 32-bit slave data is replicated {4{dat}}; ext data passes through.
  - Write data ignored for reads; dat_o is 0 on err.
  - Go to HOLD.
- HOLD:
  - Granted cyc low → s_cyc_o=0, rr_ptr toggles to the other master, → IDLE.
  - Granted cyc and stb both high (next beat of a locked sequence) → relatch and go to ACCESS without re-arbitration.
  - The other master waits regardless.
- Latency per beat: master ack arrives 1 cycle after the slave ack. Minimum beat = 3 cycles (request → s_stb → slave ack → master ack).
- The non-granted master's ack_o/err_o stay 0. Its request is never dropped, only delayed.
- The counter clears on every entry to ACCESS.
- Reset asserted mid-tenure: immediate return to reset values; no ack/err is issued for the aborted beat.

Optional Feature:
MPU_BUS_ERRLOG_EN:
- Defined: adds ports err_adr_o[31:0], err_mst_o, err_vld_o and err_clr_i.
  - On the first err (timeout or ext_err_i), capture s_adr_o and the granted master index, and set err_vld_o.
  - Later errors do not overwrite until err_clr_i is pulsed.
  - err_clr_i in the same cycle as a new error: the new error is captured.
- Not defined: ports absent; no logging logic.

Decomposition:
- Package thor2022_mpu_bus_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, HOLD);
  - the slave-select enum (SEL_PIT, SEL_PIC, SEL_EXT);
  - the default PIT_BASE/PIC_BASE constants;
  - the TIMEOUT counter width.
- One sub-module, thor2022_mpu_bus_decode: combinational adr[31:12] → slave-select enum. It is reused by the MPU top for debug.

Test Plan:
- m0 read 0xFF960010, pit_dat_i=0x12345678, pit_ack_i 2 cycles after s_stb_o → pit_cs_o=1; m0_ack_o 1 cycle after pit_ack_i; m0_dat_o=128'h12345678_12345678_12345678_12345678.
- m0 and m1 request in the same cycle after reset → m0 served first; m1 granted only after m0_cyc_i drops; the next simultaneous request goes to m1.
- m1 write 0x00001000, no ext ack → m1_err_o pulses when the counter reaches 255; s_stb_o low in the err cycle; m0 is not affected.
- m0 holds cyc through 2 beats to 0xFF9C0000/0xFF9C0004 while m1 requests → both beats go to m0 with no m1 grant in between; pic_cs_o set for both.
- rst_i low during ACCESS → all outputs 0 asynchronously; after release no ack/err for the aborted beat.
- (ERRLOG) timeout at 0x00002000 from m1, then a second timeout → err_adr_o=0x00002000, err_mst_o=1 retained; after err_clr_i, err_vld_o=0.
